hazard_controller: RTL

Pipeline sequencing controller for the five-stage RISC-V core. Sits beside `instruction_decode` and, once per cycle, decides whether the PC, IF/ID and ID/EX registers load, hold, or take a bubble/flush. It covers three conditions: load-use data hazards, branches taken in EX, and data-memory busy freezes. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_if.sv | 26 ++
 rtl/hazard_controller.sv | 81 ++++++++
 2 files changed

// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signals exchanged with the hazard controller
interface hazard_if #(parameter int CNT_W = 16);
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, state, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and memory freeze sequencing
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, FREEZE = 2'd2} state_t;
  localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYCLES - 1);
  state_t state_q, state_d, eff;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic ret_lu_q, ret_lu_d;
  logic use1, use2, hz, stall_inc, flush_inc;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  // register-use decode and load-use hazard detect; x0 is never a hazard
  always_comb begin
    use2 = bus.id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    use1 = use2 || (bus.id_opcode inside {7'b0000011, 7'b0010011, 7'b1100111});
    hz = bus.ex_memread && (bus.ex_rd != 5'd0) &&
         ((use1 && bus.ex_rd == bus.id_rs1) || (use2 && bus.ex_rd == bus.id_rs2));
  end
  // next state and control; a freeze exit behaves as the state it returns to
  always_comb begin
    eff = (state_q == FREEZE && !bus.mem_busy) ? (ret_lu_q ? LU_STALL : RUN) : state_q;
    state_d = eff;
    lu_cnt_d = lu_cnt_q;
    ret_lu_d = ret_lu_q;
    {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble} = 5'b00000;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      {ifid_flush, idex_write, idex_bubble} = 3'b111;
    end else if (bus.mem_busy) begin
      stall_inc = 1'b1;
      state_d = FREEZE;
      ret_lu_d = (state_q == FREEZE) ? ret_lu_q : (state_q == LU_STALL);
    end else if (eff == LU_STALL) begin
      {idex_write, idex_bubble} = 2'b11;
      stall_inc = 1'b1;
      lu_cnt_d = (lu_cnt_q != 3'd0) ? lu_cnt_q - 3'd1 : 3'd0;
      state_d = (lu_cnt_q > 3'd1) ? LU_STALL : RUN;
    end else if (bus.ex_branch_taken) begin
      {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble} = 5'b11111;
      flush_inc = 1'b1;
    end else if (hz) begin
      {idex_write, idex_bubble} = 2'b11;
      stall_inc = 1'b1;
      lu_cnt_d = (LOAD_STALL_CYCLES > 1) ? LU_INIT : lu_cnt_q;
      state_d = (LOAD_STALL_CYCLES > 1) ? LU_STALL : RUN;
    end else begin
      {pc_write, ifid_write, idex_write} = 3'b111;
    end
  end
  // state, stall sequencing and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      lu_cnt_q <= 3'd0;
      ret_lu_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      lu_cnt_q <= lu_cnt_d;
      ret_lu_q <= ret_lu_d;
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign bus.pc_write = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_write = idex_write;
  assign bus.idex_bubble = idex_bubble;
  assign bus.state = state_q;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule
